dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: accepts one read or
//  byte-enabled write request at a time and answers after a programmable number
//  of wait states. Register-based word RAM.
//  Sits between the core's M-stage data port and the SoC.
//  Serves as the wait-state data memory model for core bring-up and stall testing.
// PARAMETERS
//  AW         10            log2 of RAM depth in 32-bit words
//  BASE_ADDR  32'h0000_0000 byte address of word 0
//  LATENCY    2             wait cycles between acceptance and response (0..15)
//  INIT_FILE  ""            optional $readmemh image; empty = no preload
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   reset, asynchronous, active-low
//  req       in   1   request valid; sampled only while addr_ok=1
//  wen       in   4   byte write enables, bit i -> byte lane i; 4'b0000 = read
//  addr      in   32  byte address; addr[1:0] ignored (alignment checked in core)
//  wdata     in   32  write data, lane-aligned
//  addr_ok   out  1   responder can accept a request this cycle
//  data_ok   out  1   one-cycle response strobe
//  rdata     out  32  read data, valid while data_ok=1
//  resp_err  out  1   qualifies data_ok: address out of range
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, cnt=0, data_ok=0, resp_err=0, rdata=0.
//   addr_ok=0 while in reset. Any in-flight request is dropped and no write
//   occurs. RAM contents are not reset.
//  States:
//   IDLE: addr_ok=1, data_ok=0.
//     req=1 -> latch {wen,addr,wdata}, cnt=LATENCY-1, go WAIT.
//     When LATENCY=0, go directly to RESP.
//   WAIT: addr_ok=0; req ignored. cnt decrements each cycle.
//     cnt==0 -> go RESP.
//   RESP: data_ok=1 for exactly one cycle; addr_ok=1.
//     req=1 -> accept the new request, same transitions as IDLE.
//     Otherwise go IDLE.
//  Access timing:
//   RAM access is performed on the clock edge entering RESP, using the
//   latched request (live inputs when LATENCY=0).
//   A request accepted in cycle T responds in cycle T+1+LATENCY.
//   Back-to-back responses are LATENCY+1 cycles apart.
//  Range check: hit when BASE_ADDR <= addr < BASE_ADDR + 4*2**AW,
//   computed in 33-bit arithmetic so no wrap at 32'hFFFF_FFFF.
//   Word index = (addr-BASE_ADDR)[AW+1:2].
//  Read hit: rdata = mem[index], resp_err=0.
//  Write hit: bytes with wen[i]=1 are replaced, the others are kept.
//   rdata = merged word (write-echo), resp_err=0.
//  Miss (read or write): resp_err=1, rdata=0, RAM unchanged.
//  Outside RESP: data_ok=0, resp_err=0. rdata holds its last value.
//  Only one request outstanding at a time, so no RAW hazard exists
//   inside the block.
// STRUCTURE
//  dmem_resp_defines.vh:
//   - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2
//   - the WEN_READ constant
//  Sub-module byte_merge (combinational):
//   inputs old word, wdata, wen; output merged word.
//   Reused by the core's mem_ctrl store path.
//  Top level holds the FSM, the counter, the request latch, the range check
//   and the RAM array.
// TESTING  (LATENCY=2, BASE_ADDR=0, AW=10 unless noted)
//  1. Write 32'hDEADBEEF with wen=4'hF to 0x10 at T, then read 0x10:
//     data_ok at T+3 and again 3 cycles after the read is accepted;
//     rdata=32'hDEADBEEF.
//  2. Word 0x20 holds 32'h11223344. Write 32'h0000AB00 with wen=4'b0010,
//     then read: rdata=32'h1122AB44.
//  3. Read and write at addr 0x1000 (first miss): data_ok=1, resp_err=1,
//     rdata=0. A following read of 0xFFC returns its prior value.
//  4. req held high for 3 requests: responses in cycles T+3, T+6, T+9.
//     addr_ok is low in WAIT; req pulses during WAIT are not accepted.
//  5. rst=0 asserted mid-WAIT of a write to 0x30, released 2 cycles later:
//     data_ok never pulses; outputs are 0 and addr_ok is low while in reset;
//     0x30 reads back unchanged.
//  6. LATENCY=0 build: req every cycle gives data_ok every cycle,
//     with the response in cycle T+1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e : responder FSM encodings (idle / wait-state countdown / response strobe)
//   WenRead : byte-enable value that marks a request as a read
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [3:0] WenRead = 4'b0000;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge of a write into an existing 32-bit word.
// Ports:
//   old_i    in  32  current word contents
//   wdata_i  in  32  lane-aligned write data
//   wen_i    in  4   byte enables, bit i selects lane i from wdata_i
//   merged_o out 32  resulting word
module byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wen_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (wen_i[i]) begin
        merged_o[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory for the core's M-stage data port. Accepts one read or
// byte-enabled write at a time and answers LATENCY+1 cycles later with a
// one-cycle data_ok strobe. Out-of-range accesses answer with resp_err=1.
// RAM contents are not reset and have no preload.
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-low reset
//   req      in   1   request valid, taken only while addr_ok=1
//   wen      in   4   byte write enables, 4'b0000 = read
//   addr     in   32  byte address, addr[1:0] ignored
//   wdata    in   32  lane-aligned write data
//   addr_ok  out  1   a request can be accepted this cycle
//   data_ok  out  1   one-cycle response strobe
//   rdata    out  32  read data or write-echo, valid with data_ok
//   resp_err out  1   with data_ok: address out of range
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  // 33-bit bounds so a window ending at 32'hFFFF_FFFF does not wrap
  localparam logic [32:0] Base33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] Limit33 = Base33 + (33'd4 << AW);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        data_ok_q;
  logic        resp_err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [Depth];

  logic        access;
  logic [3:0]  acc_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [32:0] acc_off;
  logic        acc_hit;
  logic [AW-1:0] acc_idx;
  logic [31:0] old_word;
  logic [31:0] merged;
  logic        unused_off;

  assign addr_ok = rst & (state_q != StWait);

  // The RAM is touched on the edge that enters StResp. With no wait states
  // that is the accepting edge itself, so the live inputs are used.
  if (LATENCY == 0) begin : g_direct
    assign access    = addr_ok & req;
    assign acc_wen   = wen;
    assign acc_addr  = addr;
    assign acc_wdata = wdata;
  end else begin : g_latched
    assign access    = (state_q == StWait) && (cnt_q == 4'd0);
    assign acc_wen   = wen_q;
    assign acc_addr  = addr_q;
    assign acc_wdata = wdata_q;
  end

  assign acc_off    = {1'b0, acc_addr} - Base33;
  assign acc_hit    = ({1'b0, acc_addr} >= Base33) && ({1'b0, acc_addr} < Limit33);
  assign acc_idx    = acc_off[AW+1:2];
  assign old_word   = mem[acc_idx];
  assign unused_off = ^{acc_off[32:AW+2], acc_off[1:0]};

  byte_merge u_byte_merge (
    .old_i    (old_word),
    .wdata_i  (acc_wdata),
    .wen_i    (acc_wen),
    .merged_o (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wen_q      <= WenRead;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      data_ok_q  <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      data_ok_q  <= 1'b0;
      resp_err_q <= 1'b0;
      case (state_q)
        StIdle, StResp: begin
          if (req) begin
            wen_q   <= wen;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= CntInit;
            if (LATENCY == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (access) begin
        data_ok_q  <= 1'b1;
        resp_err_q <= ~acc_hit;
        rdata_q    <= acc_hit ? merged : 32'd0;
      end
    end
  end

  // A read has wen=WenRead, so merged equals the stored word and doubles as read data.
  always_ff @(posedge clk) begin
    if (rst && access && acc_hit && (acc_wen != WenRead)) begin
      mem[acc_idx] <= merged;
    end
  end

  assign data_ok  = data_ok_q;
  assign resp_err = resp_err_q;
  assign rdata    = rdata_q;

endmodule
